// File: rtl/sdram_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// sdram_ctrl_fsm
//
// Control state machine for a single-rank SDRAM. It runs three jobs:
//   - the power-up initialisation sequence: NOP wait, precharge-all,
//     8 auto-refreshes, then mode-register set;
//   - the periodic auto-refresh scheduler;
//   - single page-burst read and write transactions.
// The downstream command encoder turns init_state / work_state / cnt_clk /
// sdram_rd_wr into SDRAM commands. It relies on the numeric state encodings
// below, so those values must not change.
//
// Build option:
//   SDRAM_SIM_FAST_INIT_EN - when defined, the power-up NOP wait is shortened
//                            to 10 cycles for simulation. The rest of the
//                            sequence is unchanged.
//
// Ports:
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   sdram_wr_req    in   write burst request (level, held until ack)
//   sdram_rd_req    in   read burst request  (level, held until ack)
//   sdram_wr_burst  in   write burst length in words (0 is treated as 1)
//   sdram_rd_burst  in   read burst length in words  (0 is treated as 1)
//   sdram_init_done out  high while initialisation is complete
//   sdram_wr_ack    out  write data accepted this cycle (W_WRITE / W_WD)
//   sdram_rd_ack    out  read data phase active this cycle (W_RD)
//   init_state      out  initialisation state
//   work_state      out  working state
//   cnt_clk         out  cycles spent in the current state (saturating)
//   sdram_rd_wr     out  1 = read, 0 = write, held for a whole transaction
// -----------------------------------------------------------------------------
module sdram_ctrl_fsm #(
  parameter int INIT_WAIT  = 20000,
  parameter int REF_PERIOD = 781,
  parameter int TRP_CLK    = 4,
  parameter int TRC_CLK    = 6,
  parameter int TRSC_CLK   = 6,
  parameter int TRCD_CLK   = 2,
  parameter int TCL_CLK    = 3,
  parameter int TWR_CLK    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_init_done,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr
);

`ifdef SDRAM_SIM_FAST_INIT_EN
  localparam int NOP_CYCLES = 10;
`else
  localparam int NOP_CYCLES = INIT_WAIT;
`endif

  localparam int REF_W = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

  localparam logic [14:0]      NOP_LAST  = 15'(NOP_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_PERIOD - 1);
  localparam logic [REF_W-1:0] REF_ONE   = REF_W'(1);
  localparam logic [9:0]       TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0]       TRC_LAST  = 10'(TRC_CLK - 1);
  localparam logic [9:0]       TRSC_LAST = 10'(TRSC_CLK - 1);
  localparam logic [9:0]       TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0]       TCL_LAST  = 10'(TCL_CLK - 1);
  localparam logic [9:0]       TWR_LAST  = 10'(TWR_CLK - 1);
  localparam logic [3:0]       AR_TOTAL  = 4'd8;

  // Encodings are shared with the command encoder.
  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_t;

  // Saturating increment for the per-state cycle counter.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    if (v == 10'd1023) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 10'd1;
    end
  endfunction

  // A zero burst length is served as a single word.
  function automatic logic [9:0] norm_burst(input logic [9:0] b);
    if (b == 10'd0) begin
      norm_burst = 10'd1;
    end else begin
      norm_burst = b;
    end
  endfunction

  init_t            init_state_r;
  work_t            work_state_r;
  logic [9:0]       cnt_clk_r;
  logic [14:0]      nop_cnt_r;
  logic [3:0]       ar_cnt_r;
  logic [REF_W-1:0] ref_timer_r;
  logic             ref_pending_r;
  logic [9:0]       burst_r;
  logic             rd_wr_r;
  logic             wr_ack_r;
  logic             rd_ack_r;
  logic             init_done_r;

  init_t            init_next_s;
  work_t            work_next_s;
  logic             rd_wr_next_s;
  logic [9:0]       burst_next_s;
  logic             ref_hit_s;
  logic             ref_due_s;
  logic             state_chg_s;
  logic             ar_entry_s;

  // Refresh falls due on the terminal timer count. It is also visible in the
  // same cycle, so a coinciding request cannot overtake it.
  always_comb begin
    ref_hit_s   = (init_state_r == I_DONE) && (ref_timer_r == REF_LAST);
    ref_due_s   = ref_pending_r || ref_hit_s;
    state_chg_s = (init_next_s != init_state_r) || (work_next_s != work_state_r);
    ar_entry_s  = (work_state_r == W_IDLE) && (work_next_s == W_AR);
  end

  // Initialisation next-state logic.
  always_comb begin
    init_next_s = init_state_r;
    case (init_state_r)
      I_NOP: begin
        if (nop_cnt_r == NOP_LAST) begin
          init_next_s = I_PRE;
        end else begin
          init_next_s = I_NOP;
        end
      end
      I_PRE: init_next_s = I_TRP;
      I_TRP: begin
        if (cnt_clk_r == TRP_LAST) begin
          init_next_s = I_AR;
        end else begin
          init_next_s = I_TRP;
        end
      end
      I_AR: init_next_s = I_TRF;
      I_TRF: begin
        // ar_cnt_r already counts the AR that preceded this TRF.
        if (cnt_clk_r != TRC_LAST) begin
          init_next_s = I_TRF;
        end else if (ar_cnt_r == AR_TOTAL) begin
          init_next_s = I_MRS;
        end else begin
          init_next_s = I_AR;
        end
      end
      I_MRS: init_next_s = I_TRSC;
      I_TRSC: begin
        if (cnt_clk_r == TRSC_LAST) begin
          init_next_s = I_DONE;
        end else begin
          init_next_s = I_TRSC;
        end
      end
      I_DONE:  init_next_s = I_DONE;
      default: init_next_s = I_NOP;
    endcase
  end

  // Working next-state logic. Direction and burst length are captured when
  // leaving W_IDLE.
  always_comb begin
    work_next_s  = work_state_r;
    rd_wr_next_s = rd_wr_r;
    burst_next_s = burst_r;
    case (work_state_r)
      W_IDLE: begin
        if (init_state_r != I_DONE) begin
          work_next_s = W_IDLE;
        end else if (ref_due_s) begin
          work_next_s = W_AR;
        end else if (sdram_wr_req) begin
          work_next_s  = W_ACTIVE;
          rd_wr_next_s = 1'b0;
          burst_next_s = norm_burst(sdram_wr_burst);
        end else if (sdram_rd_req) begin
          work_next_s  = W_ACTIVE;
          rd_wr_next_s = 1'b1;
          burst_next_s = norm_burst(sdram_rd_burst);
        end else begin
          work_next_s = W_IDLE;
        end
      end
      W_ACTIVE: work_next_s = W_TRCD;
      W_TRCD: begin
        if (cnt_clk_r != TRCD_LAST) begin
          work_next_s = W_TRCD;
        end else if (rd_wr_r) begin
          work_next_s = W_READ;
        end else begin
          work_next_s = W_WRITE;
        end
      end
      W_WRITE: begin
        // A single-word write has no W_WD phase.
        if (burst_r == 10'd1) begin
          work_next_s = W_TWR;
        end else begin
          work_next_s = W_WD;
        end
      end
      W_WD: begin
        if (cnt_clk_r == (burst_r - 10'd2)) begin
          work_next_s = W_TWR;
        end else begin
          work_next_s = W_WD;
        end
      end
      W_TWR: begin
        if (cnt_clk_r == TWR_LAST) begin
          work_next_s = W_PRE;
        end else begin
          work_next_s = W_TWR;
        end
      end
      W_READ: work_next_s = W_CL;
      W_CL: begin
        if (cnt_clk_r == TCL_LAST) begin
          work_next_s = W_RD;
        end else begin
          work_next_s = W_CL;
        end
      end
      W_RD: begin
        if (cnt_clk_r == (burst_r - 10'd1)) begin
          work_next_s = W_PRE;
        end else begin
          work_next_s = W_RD;
        end
      end
      W_PRE: work_next_s = W_TRP;
      W_TRP: begin
        if (cnt_clk_r == TRP_LAST) begin
          work_next_s = W_IDLE;
        end else begin
          work_next_s = W_TRP;
        end
      end
      W_AR: work_next_s = W_TRFC;
      W_TRFC: begin
        if (cnt_clk_r == TRC_LAST) begin
          work_next_s = W_IDLE;
        end else begin
          work_next_s = W_TRFC;
        end
      end
      default: work_next_s = W_IDLE;
    endcase
  end

  // State registers and per-state cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_state_r <= I_NOP;
      work_state_r <= W_IDLE;
      cnt_clk_r    <= 10'd0;
    end else begin
      init_state_r <= init_next_s;
      work_state_r <= work_next_s;
      cnt_clk_r    <= state_chg_s ? 10'd0 : sat_inc(cnt_clk_r);
    end
  end

  // Power-up NOP wait counter and count of AR commands issued during init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nop_cnt_r <= 15'd0;
      ar_cnt_r  <= 4'd0;
    end else begin
      if (init_state_r == I_NOP) begin
        nop_cnt_r <= nop_cnt_r + 15'd1;
      end else begin
        nop_cnt_r <= nop_cnt_r;
      end
      if (init_state_r == I_AR) begin
        ar_cnt_r <= ar_cnt_r + 4'd1;
      end else begin
        ar_cnt_r <= ar_cnt_r;
      end
    end
  end

  // Refresh interval timer and sticky pending flag. A refresh that comes due
  // mid-burst stays pending until the machine returns to W_IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_timer_r   <= '0;
      ref_pending_r <= 1'b0;
    end else begin
      if (init_state_r == I_DONE) begin
        ref_timer_r <= ref_hit_s ? '0 : (ref_timer_r + REF_ONE);
      end else begin
        ref_timer_r <= ref_timer_r;
      end
      if (ar_entry_s) begin
        ref_pending_r <= 1'b0;
      end else if (ref_hit_s) begin
        ref_pending_r <= 1'b1;
      end else begin
        ref_pending_r <= ref_pending_r;
      end
    end
  end

  // Transaction context captured on W_IDLE -> W_ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wr_r <= 1'b1;
      burst_r <= 10'd1;
    end else begin
      rd_wr_r <= rd_wr_next_s;
      burst_r <= burst_next_s;
    end
  end

  // Status flags are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_r    <= 1'b0;
      rd_ack_r    <= 1'b0;
      init_done_r <= 1'b0;
    end else begin
      wr_ack_r    <= (work_next_s == W_WRITE) || (work_next_s == W_WD);
      rd_ack_r    <= (work_next_s == W_RD);
      init_done_r <= (init_next_s == I_DONE);
    end
  end

  assign init_state      = init_state_r;
  assign work_state      = work_state_r;
  assign cnt_clk         = cnt_clk_r;
  assign sdram_rd_wr     = rd_wr_r;
  assign sdram_wr_ack    = wr_ack_r;
  assign sdram_rd_ack    = rd_ack_r;
  assign sdram_init_done = init_done_r;

endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Self-checking bench for sdram_ctrl_fsm. The driver issues transactions and
// pushes the expected outcome (direction, burst length) into a scoreboard
// queue. An independent monitor observes each completed transaction and checks
// its shape against timing arithmetic. It also tracks refresh debt from
// elapsed time since init completed.
module tb_sdram_ctrl_fsm;
  localparam int INIT_WAIT  = 10;
  localparam int REF_PERIOD = 781;
  localparam int TRP  = 4;
  localparam int TRC  = 6;
  localparam int TRSC = 6;
  localparam int TRCD = 2;
  localparam int TCL  = 3;
  localparam int TWR  = 2;

  localparam int ST_IDLE = 0, ST_ACTIVE = 1, ST_RD = 5, ST_WRITE = 6, ST_WD = 7, ST_AR = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic [9:0] wr_burst = 10'd0;
  logic [9:0] rd_burst = 10'd0;
  logic       init_done, wr_ack, rd_ack, rd_wr;
  logic [4:0] init_state;
  logic [3:0] work_state;
  logic [9:0] cnt_clk;

  sdram_ctrl_fsm #(
    .INIT_WAIT(INIT_WAIT), .REF_PERIOD(REF_PERIOD), .TRP_CLK(TRP), .TRC_CLK(TRC),
    .TRSC_CLK(TRSC), .TRCD_CLK(TRCD), .TCL_CLK(TCL), .TWR_CLK(TWR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sdram_wr_req(wr_req), .sdram_rd_req(rd_req),
    .sdram_wr_burst(wr_burst), .sdram_rd_burst(rd_burst),
    .sdram_init_done(init_done), .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
    .init_state(init_state), .work_state(work_state), .cnt_clk(cnt_clk),
    .sdram_rd_wr(rd_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { bit is_rd; int burst; } txn_t;
  txn_t exp_q[$];
  int   exp_init[$];

  // Monitor state.
  int cyc, done_t, exp_next, init_idx, init_bad, exp_cnt, deferred;
  int txn_start, first_ack, acks, txn_bad;
  bit owed, in_txn, txn_ref, rw0, exp_dir, done_seen;

  task automatic close_txn();
    int len;
    int b;
    txn_t e;
    len = cyc - txn_start;
    in_txn = 1'b0;
    if (txn_ref) begin
      check("ref_len", len, 1 + TRC);
      check("ref_acks", acks, 0);
    end else if (exp_q.size() == 0) begin
      check("txn_expected", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      b = e.burst;
      check("direction", rw0, e.is_rd);
      check("ack_count", acks, b);
      check("first_ack", first_ack, e.is_rd ? (1 + TRCD + 1 + TCL) : (1 + TRCD));
      check("txn_len", len, e.is_rd ? (1 + TRCD + 1 + TCL + b + 1 + TRP)
                                     : (1 + TRCD + b + TWR + 1 + TRP));
      check("txn_consistency", txn_bad, 0);
    end
  endtask

  // Monitor: samples on the falling edge.
  initial begin : monitor
    bit due;
    deferred = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc = 0; done_t = -1; exp_next = -1; init_idx = 0; init_bad = 0;
        exp_cnt = 0; owed = 1'b0; in_txn = 1'b0; done_seen = 1'b0;
      end else begin
        if (exp_next >= 0) check("work_next", work_state, exp_next);
        exp_next = -1;
        if (init_state !== 5'd7) begin
          if (init_idx > 0 && init_idx < exp_init.size() && exp_init[init_idx] == exp_init[init_idx-1])
            exp_cnt++;
          else
            exp_cnt = 0;
          if (init_idx >= exp_init.size() || init_state !== exp_init[init_idx] ||
              cnt_clk !== exp_cnt || init_done !== 1'b0 || work_state !== 4'd0)
            init_bad++;
          init_idx++;
        end else begin
          if (!done_seen) begin
            done_seen = 1'b1;
            check("init_sequence", init_bad, 0);
            check("init_cycles", cyc, exp_init.size());
            check("init_done_high", init_done, 1);
          end
          done_t++;
          due = ((done_t % REF_PERIOD) == REF_PERIOD - 1);
          if (work_state == ST_IDLE) begin
            if (in_txn) close_txn();
            if (owed || due) begin
              exp_next = ST_AR;
              owed = 1'b0;
            end else if (wr_req || rd_req) begin
              exp_next = ST_ACTIVE;
              exp_dir = wr_req ? 1'b0 : 1'b1;
            end else begin
              exp_next = ST_IDLE;
            end
          end else begin
            if (due) begin
              owed = 1'b1;
              if (in_txn && !txn_ref) deferred++;
            end
            if (!in_txn) begin
              in_txn = 1'b1; txn_ref = (work_state == ST_AR); txn_start = cyc;
              rw0 = rd_wr; acks = 0; first_ack = -1; txn_bad = 0;
              if (!txn_ref) check("rd_wr_capture", rd_wr, exp_dir);
            end
            if (rd_wr !== rw0) txn_bad++;
            if (wr_ack || rd_ack) begin
              if (first_ack < 0) first_ack = cyc - txn_start;
              if (wr_ack && rd_ack) txn_bad++;
              if (rd_ack && (work_state != ST_RD || cnt_clk != acks)) txn_bad++;
              if (wr_ack && work_state != ((acks == 0) ? ST_WRITE : ST_WD)) txn_bad++;
              acks++;
            end
          end
        end
        cyc++;
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_init_state"}, init_state, 0);
    check({tag, "_work_state"}, work_state, 0);
    check({tag, "_cnt_clk"}, cnt_clk, 0);
    check({tag, "_rd_wr"}, rd_wr, 1);
    check({tag, "_acks"}, {wr_ack, rd_ack}, 0);
    check({tag, "_init_done"}, init_done, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!init_done && n < 500) begin wait_cycle(); n++; end
    check("init_done_seen", init_done, 1);
  endtask

  task automatic wait_ack(input bit is_rd);
    int n = 0;
    while (!(is_rd ? rd_ack : wr_ack) && n < 3000) begin wait_cycle(); n++; end
    check(is_rd ? "rd_ack_seen" : "wr_ack_seen", is_rd ? rd_ack : wr_ack, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (work_state != ST_IDLE && n < 3000) begin wait_cycle(); n++; end
    check("idle_reached", work_state, ST_IDLE);
  endtask

  task automatic issue(input bit is_rd, input int b);
    txn_t e;
    e.is_rd = is_rd;
    e.burst = (b == 0) ? 1 : b;
    exp_q.push_back(e);
    if (is_rd) begin rd_burst = 10'(b); rd_req = 1'b1; end
    else       begin wr_burst = 10'(b); wr_req = 1'b1; end
  endtask

  task automatic run_txn(input bit is_rd, input int b);
    issue(is_rd, b);
    wait_ack(is_rd);
    if (is_rd) rd_req = 1'b0; else wr_req = 1'b0;
    // Burst inputs are scrambled in flight; the DUT must ignore them.
    wr_burst = 10'($urandom_range(0, 1023));
    rd_burst = 10'($urandom_range(0, 1023));
    wait_idle();
    repeat ($urandom_range(0, 3)) wait_cycle();
  endtask

  initial begin : driver
    int d0;
    int n;
    repeat (10) exp_init.push_back(1);
    for (int i = 0; i < 10; i++) exp_init[i] = 0;
    exp_init.push_back(1);
    repeat (TRP) exp_init.push_back(2);
    for (int k = 0; k < 8; k++) begin
      exp_init.push_back(3);
      repeat (TRC) exp_init.push_back(4);
    end
    exp_init.push_back(5);
    repeat (TRSC) exp_init.push_back(6);

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    wait_done();
    wait_cycle();

    // Directed: write burst 8, read 1, zero-length bursts.
    run_txn(1'b0, 8);
    run_txn(1'b1, 1);
    run_txn(1'b0, 0);
    run_txn(1'b1, 0);

    // Simultaneous requests: write first, read served right after.
    issue(1'b0, 5);
    issue(1'b1, 6);
    wait_ack(1'b0);
    wr_req = 1'b0;
    wait_ack(1'b1);
    rd_req = 1'b0;
    wait_idle();

    // 512-word read placed so a refresh falls due mid-burst.
    n = 0;
    while ((done_t % REF_PERIOD) != 400 && n < 2000) begin wait_cycle(); n++; end
    check("phase_reached", done_t % REF_PERIOD, 400);
    d0 = deferred;
    run_txn(1'b1, 512);
    check("refresh_deferred", deferred - d0, 1);

    // Randomised traffic.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        issue(1'b0, $urandom_range(0, 20));
        issue(1'b1, $urandom_range(0, 20));
        wait_ack(1'b0); wr_req = 1'b0;
        wait_ack(1'b1); rd_req = 1'b0;
        wait_idle();
      end else begin
        run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 40));
      end
    end

    // Reset during a write data phase.
    issue(1'b0, 16);
    n = 0;
    while (work_state != ST_WD && n < 3000) begin wait_cycle(); n++; end
    check("reached_wd", work_state, ST_WD);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete();
    wr_req = 1'b0;
    repeat (2) wait_cycle();
    rst_n = 1'b1;
    wait_done();
    wait_cycle();
    run_txn(1'b0, 4);
    run_txn(1'b1, 3);

    repeat (3) wait_cycle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
